// File: rtl/iadc_pkg.sv
// rtl/iadc_pkg.sv - shared types and defaults for the incremental-ADC conversion sequencer
package iadc_pkg;

  localparam int OSR_W_DEF   = 10;
  localparam int RST_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESET   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/iadc_seq_counter.sv
// rtl/iadc_seq_counter.sv - loadable down-counter timing the RESET and CONVERT windows
module iadc_seq_counter #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; the count parks at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/iadc_conversion_sequencer.sv
// rtl/iadc_conversion_sequencer.sv - integrator reset / conversion window / done sequencing with chopper
module iadc_conversion_sequencer
  import iadc_pkg::*;
#(
  parameter int OSR_W   = OSR_W_DEF,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_cont_mode,
  input  logic             i_chop_en,
  input  logic             i_abort,
  input  logic [OSR_W-1:0] i_osr,
  output logic             o_clkgen_en,
  output logic             o_int_rst,
  output logic             o_dec_clr,
  output logic             o_dec_en,
  output logic             o_chop_phase,
  output logic             o_busy,
  output logic             o_conv_done,
  output logic [OSR_W-1:0] o_sample_cnt
);

  localparam logic [OSR_W-1:0] RST_LOAD = OSR_W'(RST_CYC - 1);
  localparam logic [OSR_W-1:0] OSR_MIN  = OSR_W'(2);

  state_e           r_state;
  logic [OSR_W-1:0] r_osr_l;
  logic             r_chop;
  logic             r_clkgen_en;
  logic             r_int_rst;
  logic             r_dec_clr;
  logic             r_dec_en;
  logic             r_busy;
  logic             r_conv_done;

  logic [OSR_W-1:0] w_osr_clamp;
  logic             w_cnt_load;
  logic [OSR_W-1:0] w_cnt_val;
  logic             w_cnt_en;
  logic [OSR_W-1:0] w_cnt;
  logic             w_cnt_zero;

  // The integrator needs at least two samples for a meaningful result
  assign w_osr_clamp = (i_osr < OSR_MIN) ? OSR_MIN : i_osr;

  // Counter is loaded on entry to RESET and to CONVERT, and counts down while in either
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = RST_LOAD;
    w_cnt_en   = 1'b0;
    if (!i_abort) begin
      case (r_state)
        ST_IDLE:    w_cnt_load = i_start;
        ST_RESET: begin
          if (w_cnt_zero) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = r_osr_l - OSR_W'(1);
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        ST_CONVERT: w_cnt_en   = !w_cnt_zero;
        ST_DONE:    w_cnt_load = i_cont_mode;
        default:    w_cnt_load = 1'b0;
      endcase
    end
  end

  iadc_seq_counter #(
    .W (OSR_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Sequencer FSM; every output is registered from the state being entered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_osr_l     <= '0;
      r_chop      <= 1'b0;
      r_clkgen_en <= 1'b0;
      r_int_rst   <= 1'b0;
      r_dec_clr   <= 1'b0;
      r_dec_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_conv_done <= 1'b0;
    end else begin
      r_clkgen_en <= 1'b0;
      r_int_rst   <= 1'b0;
      r_dec_clr   <= 1'b0;
      r_dec_en    <= 1'b0;
      r_conv_done <= 1'b0;
      r_busy      <= 1'b1;
      if (i_abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state   <= ST_RESET;
              r_osr_l   <= w_osr_clamp;
              r_int_rst <= 1'b1;
              r_dec_clr <= 1'b1;
            end else begin
              r_busy <= 1'b0;
            end
          end
          ST_RESET: begin
            if (w_cnt_zero) begin
              r_state     <= ST_CONVERT;
              r_clkgen_en <= 1'b1;
              r_dec_en    <= 1'b1;
            end else begin
              r_int_rst <= 1'b1;
              r_dec_clr <= 1'b1;
            end
          end
          ST_CONVERT: begin
            if (w_cnt_zero) begin
              r_state     <= ST_DONE;
              r_conv_done <= 1'b1;
            end else begin
              r_clkgen_en <= 1'b1;
              r_dec_en    <= 1'b1;
            end
          end
          ST_DONE: begin
            if (i_chop_en) begin
              r_chop <= !r_chop;
            end
            if (i_cont_mode) begin
              r_state   <= ST_RESET;
              r_osr_l   <= w_osr_clamp;
              r_int_rst <= 1'b1;
              r_dec_clr <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_clkgen_en  = r_clkgen_en;
  assign o_int_rst    = r_int_rst;
  assign o_dec_clr    = r_dec_clr;
  assign o_dec_en     = r_dec_en;
  assign o_chop_phase = r_chop;
  assign o_busy       = r_busy;
  assign o_conv_done  = r_conv_done;
  assign o_sample_cnt = (r_state == ST_CONVERT) ? (r_osr_l - OSR_W'(1) - w_cnt) : '0;

endmodule

// File: tb/tb_iadc_conversion_sequencer.sv
// tb/tb_iadc_conversion_sequencer.sv - self-checking bench for the conversion sequencer
module tb_iadc_conversion_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont_mode = 1'b0;
  logic       chop_en = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] osr = 10'd8;
  logic       clkgen_en, int_rst, dec_clr, dec_en, chop_phase, busy, conv_done;
  logic [9:0] sample_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int rst_len;
    int clk_len;
    int last_sample;
    int total;
    bit chop;
  } exp_t;

  typedef struct {
    logic [9:0] osr;
    bit         mid_en;
    logic [9:0] osr_mid;
    int         exp_len;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  bit   m_chop = 1'b0;
  int   n_done = 0;

  int m_len = 0, m_rst = 0, m_clk = 0, m_last = 0;
  bit m_seq_bad = 1'b0;
  bit prev_done = 1'b0;

  iadc_conversion_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_cont_mode  (cont_mode),
    .i_chop_en    (chop_en),
    .i_abort      (abort),
    .i_osr        (osr),
    .o_clkgen_en  (clkgen_en),
    .o_int_rst    (int_rst),
    .o_dec_clr    (dec_clr),
    .o_dec_en     (dec_en),
    .o_chop_phase (chop_phase),
    .o_busy       (busy),
    .o_conv_done  (conv_done),
    .o_sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sb(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() <= n) return;
      step();
    end
    checks++;
    flag("scoreboard_timeout");
    sb.delete();
  endtask

  task automatic clr_meas();
    m_len = 0; m_rst = 0; m_clk = 0; m_last = 0; m_seq_bad = 1'b0;
  endtask

  // Monitor: invariants every cycle, per-conversion measurements scored at conv_done
  always @(negedge clk) begin
    if (rst) begin
      clr_meas();
      prev_done = 1'b0;
    end else begin
      if (clkgen_en && int_rst) flag("clkgen_and_int_rst");
      if (dec_en != clkgen_en) flag("dec_en_vs_clkgen");
      if (dec_clr != int_rst) flag("dec_clr_vs_int_rst");
      if (conv_done && prev_done) flag("conv_done_width");
      if ((int_rst || clkgen_en || conv_done) && !busy) flag("busy_low_while_active");
      if (!clkgen_en && sample_cnt != 10'd0) flag("sample_cnt_outside_convert");
      prev_done = conv_done;
      if (busy) begin
        m_len++;
        if (int_rst) m_rst++;
        if (clkgen_en) begin
          if (int'(sample_cnt) != m_clk) m_seq_bad = 1'b1;
          m_last = int'(sample_cnt);
          m_clk++;
        end
      end
      if (conv_done) begin
        exp_t e;
        n_done++;
        if (sb.size() == 0) begin
          checks++;
          flag("unexpected_conv_done");
        end else begin
          e = sb.pop_front();
          chk("int_rst_cycles", m_rst, e.rst_len);
          chk("clkgen_cycles", m_clk, e.clk_len);
          chk("last_sample_cnt", m_last, e.last_sample);
          chk("conv_total_cycles", m_len, e.total);
          chk("chop_phase", int'(chop_phase), int'(e.chop));
          chk("sample_cnt_sequence", int'(m_seq_bad), 0);
        end
        clr_meas();
      end else if (!busy) begin
        clr_meas();
      end
    end
  end

  task automatic push_exp(input int len, input bit chop);
    exp_t e;
    e.rst_len = 4;
    e.clk_len = len;
    e.last_sample = len - 1;
    e.total = 4 + len + 1;
    e.chop = chop;
    sb.push_back(e);
  endtask

  task automatic run_single(input vec_t v);
    osr = v.osr;
    push_exp(v.exp_len, m_chop);
    start = 1'b1;
    step();
    start = 1'b0;
    if (v.mid_en) begin
      step();
      step();
      osr = v.osr_mid;
    end
    wait_sb(0, 2000);
    step();
    if (chop_en) m_chop = !m_chop;
    chk("idle_after_single", int'(busy), 0);
    chk("chop_after_single", int'(chop_phase), int'(m_chop));
  endtask

  initial begin
    int base;
    vecs.push_back('{osr: 10'd8,    mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 8});
    vecs.push_back('{osr: 10'd0,    mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 2});
    vecs.push_back('{osr: 10'd1,    mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 2});
    vecs.push_back('{osr: 10'd2,    mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 2});
    vecs.push_back('{osr: 10'd3,    mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 3});
    vecs.push_back('{osr: 10'd5,    mid_en: 1'b1, osr_mid: 10'd100, exp_len: 5});
    vecs.push_back('{osr: 10'd1023, mid_en: 1'b0, osr_mid: 10'd0,   exp_len: 1023});

    step();
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_outputs", int'({clkgen_en, int_rst, dec_clr, dec_en, conv_done}), 0);
    chk("reset_chop", int'(chop_phase), 0);
    chk("reset_sample_cnt", int'(sample_cnt), 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_single(vecs[i]);

    // Continuous mode with chopping: four back-to-back conversions, chop 0,1,0,1
    cont_mode = 1'b1;
    chop_en = 1'b1;
    osr = 10'd16;
    for (int k = 0; k < 4; k++) push_exp(16, m_chop ^ k[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_sb(1, 200);
    step();
    cont_mode = 1'b0;
    wait_sb(0, 200);
    step();
    chk("cont_idle", int'(busy), 0);
    chk("cont_chop_final", int'(chop_phase), int'(m_chop));

    // One more chopped conversion leaves chop_phase at 1
    run_single('{osr: 10'd8, mid_en: 1'b0, osr_mid: 10'd0, exp_len: 8});
    chop_en = 1'b0;

    // Start pulsed mid-conversion is ignored
    base = n_done;
    osr = 10'd8;
    push_exp(8, m_chop);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_sb(0, 200);
    repeat (30) step();
    chk("start_while_busy_done_count", n_done - base, 1);
    chk("start_while_busy_idle", int'(busy), 0);

    // Abort at sample 5 of CONVERT
    base = n_done;
    osr = 10'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (clkgen_en && sample_cnt == 10'd5) break;
      step();
    end
    chk("abort_reached_sample5", int'(sample_cnt), 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outputs", int'({clkgen_en, int_rst, dec_en, conv_done}), 0);
    chk("abort_chop_kept", int'(chop_phase), int'(m_chop));
    repeat (30) step();
    chk("abort_no_done", n_done - base, 0);

    // Abort and start together in IDLE
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", int'(busy), 0);
    step();
    chk("abort_start_no_rst", int'(int_rst), 0);

    // Asynchronous reset while in RESET
    osr = 10'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("in_reset_state", int'(int_rst), 1);
    #2 rst = 1'b1;
    #1;
    m_chop = 1'b0;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_outputs", int'({clkgen_en, int_rst, dec_clr, dec_en, conv_done}), 0);
    chk("async_rst_chop", int'(chop_phase), 0);
    step();
    rst = 1'b0;
    step();
    run_single('{osr: 10'd4, mid_en: 1'b0, osr_mid: 10'd0, exp_len: 4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
